uart_rx_frontend: RTL

UART_RX_FRONTEND -- requirements
Module: uart_rx_frontend

---
 rtl/uart_pkg.sv | 23 ++
 rtl/sync_fifo.sv | 59 +++++
 rtl/uart_rx_frontend.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive front end: FSM encoding,
// oversampling constants and the baud divider calculation.
package uart_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StWaitHigh
  } rx_state_e;

  localparam int unsigned OVERSAMPLE = 16;
  localparam int unsigned SAMPLE_LO  = 7;
  localparam int unsigned SAMPLE_MID = 8;
  localparam int unsigned SAMPLE_HI  = 9;

  // Clocks per oversample tick, rounded to nearest.
  function automatic int unsigned calc_div(input int unsigned clk_hz, input int unsigned baud);
    return (clk_hz + (OVERSAMPLE / 2) * baud) / (OVERSAMPLE * baud);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO. Pointers carry one extra wrap bit so that
// full and empty are told apart by the MSB.
module sync_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  output logic             full_o,
  input  logic             pop_i,
  output logic             empty_o,
  output logic [Width-1:0] head_o
);

  localparam int unsigned AddrW = $clog2(Depth);
  localparam int unsigned PtrW  = AddrW + 1;

  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [Width-1:0] mem_q [Depth];
  logic             do_push, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[PtrW-1] != rd_ptr_q[PtrW-1]) &&
                   (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]);
  assign do_pop  = pop_i && !empty_o;
  // A push into a full FIFO is only taken when the head leaves the same cycle.
  assign do_push = push_i && (!full_o || do_pop);
  assign head_o  = mem_q[rd_ptr_q[AddrW-1:0]];

  // Pointer advance.
  always_comb begin
    wr_ptr_d = wr_ptr_q + PtrW'(do_push);
    rd_ptr_d = rd_ptr_q + PtrW'(do_pop);
  end

  // Pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage; cleared on reset so the head reads 0 while empty after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q <= '{default: '0};
    end else if (do_push) begin
      mem_q[wr_ptr_q[AddrW-1:0]] <= data_i;
    end
  end

endmodule

// File: rtl/uart_rx_frontend.sv
// UART receiver: synchronises the line, oversamples 16x with 3-point
// majority voting, and buffers received bytes in a small FIFO.
module uart_rx_frontend
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 50000000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_io,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       rx_busy
);

  localparam int unsigned Div  = calc_div(CLK_HZ, BAUD);
  localparam int unsigned DivW = (Div > 1) ? $clog2(Div) : 1;

  rx_state_e       state_q, state_d;
  logic            rx_meta_q, rx_sync_q, rx_prev_q;
  logic [DivW-1:0] div_cnt_q;
  logic [3:0]      phase_q, phase_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      shift_q, shift_d;
  logic [1:0]      samp_q, samp_d;
  logic [3:0]      high_cnt_q, high_cnt_d;
  logic            start_edge, tick, maj, mid_tick, end_tick;
  logic            push_byte, fifo_full, fifo_empty, pop;

  assign start_edge = (state_q == StIdle) && rx_prev_q && !rx_sync_q;
  assign tick       = (div_cnt_q == DivW'(Div - 1));
  assign mid_tick   = tick && (phase_q == 4'(SAMPLE_HI));
  assign end_tick   = tick && (phase_q == 4'(OVERSAMPLE - 1));
  // Third vote is the live line value at the SAMPLE_HI tick.
  assign maj        = (samp_q[0] & samp_q[1]) | (rx_sync_q & (samp_q[0] | samp_q[1]));

  assign rx_valid = !fifo_empty;
  assign pop      = rx_valid && rx_ready;
  assign overrun  = push_byte && fifo_full && !pop;
  assign rx_busy  = (state_q != StIdle);

  // Two-flop synchroniser plus previous value for falling-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= rx_io;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  // Oversample divider: free-running, realigned to the start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_q <= '0;
    end else if (start_edge || tick) begin
      div_cnt_q <= '0;
    end else begin
      div_cnt_q <= div_cnt_q + 1'b1;
    end
  end

  // Next-state logic, sampling, shifting and event pulses.
  always_comb begin
    state_d    = state_q;
    phase_d    = tick ? phase_q + 4'd1 : phase_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    samp_d     = samp_q;
    high_cnt_d = high_cnt_q;
    push_byte  = 1'b0;
    frame_err  = 1'b0;

    if (tick && (phase_q == 4'(SAMPLE_LO)))  samp_d[0] = rx_sync_q;
    if (tick && (phase_q == 4'(SAMPLE_MID))) samp_d[1] = rx_sync_q;

    unique case (state_q)
      StIdle: begin
        if (start_edge) begin
          state_d = StStart;
          phase_d = 4'd0;
        end
      end
      StStart: begin
        if (mid_tick && maj) begin
          state_d = StIdle;
        end else if (end_tick) begin
          state_d   = StData;
          bit_cnt_d = 3'd0;
        end
      end
      StData: begin
        if (mid_tick) shift_d = {maj, shift_q[7:1]};
        if (end_tick) begin
          if (bit_cnt_q == 3'd7) state_d = StStop;
          else bit_cnt_d = bit_cnt_q + 3'd1;
        end
      end
      StStop: begin
        // Decide at mid-stop so the next start edge can be caught early.
        if (mid_tick) begin
          if (maj) begin
            push_byte = 1'b1;
            state_d   = StIdle;
          end else begin
            frame_err  = 1'b1;
            high_cnt_d = 4'd0;
            state_d    = StWaitHigh;
          end
        end
      end
      StWaitHigh: begin
        if (tick) begin
          if (!rx_sync_q) high_cnt_d = 4'd0;
          else if (high_cnt_q == 4'd15) state_d = StIdle;
          else high_cnt_d = high_cnt_q + 4'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      phase_q    <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      samp_q     <= '0;
      high_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      samp_q     <= samp_d;
      high_cnt_q <= high_cnt_d;
    end
  end

  sync_fifo #(
    .Width(8),
    .Depth(FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .push_i (push_byte),
    .data_i (shift_q),
    .full_o (fifo_full),
    .pop_i  (pop),
    .empty_o(fifo_empty),
    .head_o (rx_data)
  );

endmodule
